// File: rtl/score_display_scheduler.sv
// score_display_scheduler
// Takes binary scores over a valid/ready handshake and converts them to two BCD
// digits with a sequential double-dabble engine. The result is committed to the
// display registers in one cycle. The two digits are time-multiplexed onto one
// shared decoder path, with leading-zero blanking and a game-over flash.
//
// Handshake: a transfer happens on a rising clk edge where score_valid and
// score_ready are both 1. score_in is sampled only on that edge. score_valid
// seen while score_ready is 0 is ignored, so the source must hold score_valid
// and score_in until the transfer happens.
module score_display_scheduler #(
  parameter int SCAN_DIV      = 2,  // clock cycles per digit slot (>= 1)
  parameter int FLASH_DIV     = 4,  // full frames per flash half-period (>= 1)
  parameter int BLANK_LEADING = 1   // 1: blank the tens digit while it is 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       score_valid,
  input  logic [6:0] score_in,
  output logic       score_ready,
  input  logic       game_complete,
  output logic       busy,
  output logic [1:0] digit_sel,
  output logic [3:0] digit_val,
  output logic       digit_en,
  output logic [1:0] dbg_state
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_COMMIT  = 2'd2;

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRAME_W = $clog2(FLASH_DIV + 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FLASH_DIV - 1);

  // Conversion engine state
  logic [1:0] state_q, state_d;
  logic [6:0] operand_q, operand_d;
  logic [7:0] bcd_q, bcd_d;
  logic [2:0] iter_q, iter_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       score_ready_q, score_ready_d;
  logic       busy_q, busy_d;

  // Scanner / flash state
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic               slot_q, slot_d;  // 0 = ones slot, 1 = tens slot
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               flash_phase_q, flash_phase_d;
  logic [1:0]         digit_sel_q, digit_sel_d;
  logic [3:0]         digit_val_q, digit_val_d;
  logic               digit_en_q, digit_en_d;

  logic [3:0] adj_hi, adj_lo;
  logic       scan_wrap;
  logic       frame_done;

  // Conversion FSM: IDLE accepts a score, CONVERT runs 7 add-3/shift steps,
  // COMMIT copies the BCD accumulator into the display registers.
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    bcd_d     = bcd_q;
    iter_d    = iter_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    // Add-3 is local to each nibble. No carry crosses between nibbles.
    adj_hi = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    adj_lo = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    case (state_q)
      ST_IDLE: begin
        if (score_valid && score_ready_q) begin
          // Saturate at 99 so the accumulator never needs a hundreds digit.
          operand_d = (score_in > 7'd99) ? 7'd99 : score_in;
          bcd_d     = 8'd0;
          iter_d    = 3'd0;
          state_d   = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        {bcd_d, operand_d} = {adj_hi[2:0], adj_lo, operand_q, 1'b0};
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd6) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        tens_d  = bcd_q[7:4];
        ones_d  = bcd_q[3:0];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    score_ready_d = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
  end

  // Conversion registers and display registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      operand_q     <= 7'd0;
      bcd_q         <= 8'd0;
      iter_q        <= 3'd0;
      tens_q        <= 4'd0;
      ones_q        <= 4'd0;
      score_ready_q <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      operand_q     <= operand_d;
      bcd_q         <= bcd_d;
      iter_q        <= iter_d;
      tens_q        <= tens_d;
      ones_q        <= ones_d;
      score_ready_q <= score_ready_d;
      busy_q        <= busy_d;
    end
  end

  // Free-running scanner, frame-based flash timer and registered digit outputs.
  // The scanner runs independently of the FSM, so a commit never disturbs it.
  always_comb begin
    scan_wrap     = (scan_cnt_q == SCAN_LAST);
    scan_cnt_d    = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    slot_d        = scan_wrap ? ~slot_q : slot_q;
    frame_done    = scan_wrap && slot_q;
    frame_cnt_d   = frame_cnt_q;
    flash_phase_d = flash_phase_q;
    if (!game_complete) begin
      frame_cnt_d   = '0;
      flash_phase_d = 1'b0;
    end else if (frame_done) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d   = '0;
        flash_phase_d = ~flash_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
    digit_sel_d = slot_d ? 2'b10 : 2'b01;
    digit_val_d = slot_d ? tens_q : ones_q;
    digit_en_d  = !(flash_phase_d ||
                    (slot_d && (BLANK_LEADING != 0) && (tens_q == 4'd0)));
  end

  // Scanner, flash and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q    <= '0;
      slot_q        <= 1'b0;
      frame_cnt_q   <= '0;
      flash_phase_q <= 1'b0;
      digit_sel_q   <= 2'b01;
      digit_val_q   <= 4'd0;
      digit_en_q    <= 1'b1;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      slot_q        <= slot_d;
      frame_cnt_q   <= frame_cnt_d;
      flash_phase_q <= flash_phase_d;
      digit_sel_q   <= digit_sel_d;
      digit_val_q   <= digit_val_d;
      digit_en_q    <= digit_en_d;
    end
  end

  assign score_ready = score_ready_q;
  assign busy        = busy_q;
  assign digit_sel   = digit_sel_q;
  assign digit_val   = digit_val_q;
  assign digit_en    = digit_en_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/score_display_scheduler.md
Name: score_display_scheduler

Overview:
- Controller that sits between the score tracker and the two-digit seven-segment decoders.
- Accepts binary score updates through a valid/ready handshake and converts them to BCD with a sequential double-dabble engine.
- Commits the result atomically to display registers.
- Time-multiplexes the ones and tens digits onto a single shared decoder path, with leading-zero blanking and a game-over flash.

Parameters:
- SCAN_DIV, 2, clock cycles per digit slot; legal range is 1 or more.
- FLASH_DIV, 4, full scan frames (ones slot plus tens slot) per flash half-period; legal range is 1 or more.
- BLANK_LEADING, 1, when 1 the tens digit is suppressed while it is 0.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; asynchronous, active-high.
- score_valid, input, 1, new score offered.
- score_in, input, 7, binary score (0..127).
- score_ready, output, 1, block can accept a score.
- game_complete, input, 1, level signal; enables flashing.
- busy, output, 1, conversion in progress.
- digit_sel, output, 2, one-hot slot select: bit0 = ones, bit1 = tens.
- digit_val, output, 4, BCD value for the selected digit.
- digit_en, output, 1, decoder enable for the selected digit.

Behaviour:
- Reset is asynchronous, active-high; rst is the reset and clk the clock.
- Reset values:
  - FSM = IDLE; score_ready = 1; busy = 0.
  - Display registers tens = 0, ones = 0.
  - digit_sel = 01; digit_val = 0; digit_en = 1.
  - Scan counter = 0; frame counter = 0; flash_phase = 0.
- All outputs are registered.
- Conversion FSM has three states: IDLE, CONVERT, COMMIT.
  - IDLE: score_ready = 1, busy = 0. A transfer occurs when score_valid && score_ready at a clock edge.
    - On transfer: load operand = min(score_in, 99) into a 7-bit shift register, clear the 8-bit BCD accumulator, set iteration count = 0, go to CONVERT.
  - CONVERT: score_ready = 0, busy = 1. Each cycle, for each BCD nibble that is >= 5, add 3; then shift {bcd, operand} left by 1.
    - After exactly 7 iterations, go to COMMIT.
  - COMMIT (1 cycle): write tens/ones display registers from the accumulator, return to IDLE. busy is still 1 in this cycle.
- Latency and throughput:
  - Transfer at edge N.
  - Display registers update at edge N+8.
  - digit_val reflects the new value at edge N+9 if that slot is currently selected.
  - score_ready returns to 1 after edge N+8, giving 1 accepted score per 9 cycles maximum.
- score_valid while score_ready = 0 is ignored. The source must hold score_valid and score_in until a transfer occurs. score_in is sampled only at the transfer edge.
- Saturation: any score_in > 99 converts as 99. Values 0..99 convert exactly.
- Scanner:
  - The scan counter counts 0..SCAN_DIV-1 and free-runs independently of the FSM.
  - At wrap, the slot toggles between ones and tens.
  - Each ones-to-tens-to-ones pass is one frame.
  - A commit never resets or stretches the current slot.
- Outputs per slot:
  - digit_sel is one-hot for the active slot.
  - digit_val = the display register for that slot.
- digit_en rules:
  - digit_en = 0 in the tens slot when BLANK_LEADING = 1 and tens = 0.
  - digit_en = 0 whenever flash_phase = 1.
  - Otherwise digit_en = 1.
- Flash:
  - While game_complete = 1, the frame counter counts completed frames. At FLASH_DIV frames, it clears and flash_phase toggles.
  - When game_complete = 0, the frame counter and flash_phase clear on the next edge and the display is steady.
- A score update during game_complete is accepted normally; flashing continues.
- Reset mid-conversion aborts the conversion, clears the display to 0, and score_ready = 1 after release.
- Width rules: BCD add-3 is nibble-local with no carry between nibbles. The accumulator never exceeds 0x99 because of saturation.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> score_ready = 1, digit_sel = 01, digit_val = 0, digit_en = 1 immediately. Scan then alternates every 2 cycles and the tens slot has digit_en = 0.
- Score 42: transfer at edge N -> busy = 1 for edges N..N+8. Registers tens = 4, ones = 2 at N+8. Tens slot shows digit_val = 4, digit_en = 1; ones slot shows 2.
- Score 7 with BLANK_LEADING = 1 -> ones = 7 with digit_en = 1; tens slot has digit_en = 0. Score 10 -> tens = 1 with digit_en = 1, ones = 0.
- Saturation: score_in = 120 -> displays 9/9. Back-to-back scores 5 then 63 with score_valid held -> second transfer occurs exactly 9 cycles after the first, final display is 6/3, and there is no intermediate corruption.
- Flash: score 88, game_complete = 1 -> digit_en = 1 for 4 frames (16 cycles at defaults), then 0 for 16 cycles, repeating. Drop game_complete -> digit_en = 1 steady from the next edge.
- Reset at the 4th CONVERT cycle of score 55 -> display = 0 and busy = 0. A new score 31 afterwards converts normally to 3/1.
